// File: rtl/spi_slave_cfg_if.sv
// Bus bundle for spi_slave_cfg: SPI pins plus the tx holding-register and rx-word handshakes.
// tx_underrun exists only when SPI_SLAVE_TX_UNDERRUN_EN is defined.
interface spi_slave_cfg_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  SCLK;
    logic                  MOSI;
    logic                  SS_n;
    logic                  MISO;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic                  tx_underrun;
`endif

    modport slave (
        input  SCLK, MOSI, SS_n, tx_data, tx_valid,
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        output tx_underrun,
`endif
        output MISO, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output SCLK, MOSI, SS_n, tx_data, tx_valid,
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        input  tx_underrun,
`endif
        input  MISO, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable width and mode; pins are synchronised and edge-detected in clk.
// Define SPI_SLAVE_TX_UNDERRUN_EN to add the tx_underrun pulse on loads from an empty holding reg.
module spi_slave_cfg #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    spi_slave_cfg_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StActive} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q, post_rst_q, ss_armed_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   lead_edge, trail_edge, drive_edge, sample_edge, ss_fall, ss_rise;
    logic                   pend_q, pend_d;
    logic                   do_load, do_shift, do_sample, do_abort, word_end, tx_accept;
    logic [CntW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]  tx_shift_q, rx_shift_q, rx_data_q, hold_q;
    logic                   hold_full_q, done_q, rx_valid_q;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    assign lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
    assign trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign ss_fall     = ss_prev_q && !ss_s;
    assign ss_rise     = !ss_prev_q && ss_s;

    // A select held low through rst must not start a transfer: arm only after a real high is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= CPOL;
            ss_prev_q   <= 1'b1;
            post_rst_q  <= 1'b0;
            ss_armed_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            post_rst_q  <= 1'b1;
            if (post_rst_q && ss_sync_q[0]) begin
                ss_armed_q <= 1'b1;
            end
        end
    end

    // pend_q: CPHA=0 means "next drive edge loads"; CPHA=1 means "next drive edge holds the MSB".
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        do_abort  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall && ss_armed_q) begin
                    state_d = StActive;
                    do_load = 1'b1;
                    pend_d  = CPHA;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_d  = StIdle;
                    do_abort = 1'b1;
                    pend_d   = 1'b0;
                end else if (drive_edge) begin
                    pend_d = 1'b0;
                    if (!pend_q) begin
                        do_shift = 1'b1;
                    end else if (!CPHA) begin
                        do_load = 1'b1;
                    end
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        pend_d  = 1'b1;
                        do_load = CPHA;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign word_end  = do_sample && (bit_cnt_q == LastBit);
    assign tx_accept = bus.tx_valid && !hold_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (do_abort) begin
                tx_shift_q <= '0;
                bit_cnt_q  <= '0;
            end else if (do_load) begin
                tx_shift_q <= hold_full_q ? hold_q : '0;
            end else if (do_shift) begin
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (do_sample) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                bit_cnt_q  <= word_end ? '0 : bit_cnt_q + CntW'(1);
            end
            done_q     <= word_end;
            rx_valid_q <= done_q;
            if (done_q) begin
                rx_data_q <= rx_shift_q;
            end
            // Accept wins over a same-cycle load: the load already took the pre-accept contents.
            if (tx_accept) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end else if (do_load) begin
                hold_full_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic underrun_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= do_load && !hold_full_q;
        end
    end
    assign bus.tx_underrun = underrun_q;
`endif

    assign bus.MISO     = tx_shift_q[DATA_WIDTH-1];
    assign bus.tx_ready = !hold_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = !ss_s;
endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: four 8-bit instances (modes 0..3) and one 16-bit mode-0 instance
// share one bit-banged master; received words are checked against a queue of expected values.
module tb_spi_slave_cfg;
    localparam int H    = 6;
    localparam int NDut = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sclk_base = 1'b0;
    logic            mosi = 1'b0;
    logic [NDut-1:0] ss_n_v = '1;
    logic [NDut-1:0] txv_v = '0;
    logic [15:0]     tx_data = '0;
    logic [NDut-1:0] miso_v, rxv_v, txr_v, busy_v;
    logic [NDut-1:0] rxv_prev = '0;
    logic [15:0]     rxd_v [NDut];
    int              sel = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [15:0]     rx_exp [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_cfg_if #(.DATA_WIDTH(8)) bus ();
        assign bus.SCLK     = (g >= 2) ? ~sclk_base : sclk_base;
        assign bus.MOSI     = mosi;
        assign bus.SS_n     = ss_n_v[g];
        assign bus.tx_data  = tx_data[7:0];
        assign bus.tx_valid = txv_v[g];
        assign miso_v[g]    = bus.MISO;
        assign rxv_v[g]     = bus.rx_valid;
        assign txr_v[g]     = bus.tx_ready;
        assign busy_v[g]    = bus.busy;
        assign rxd_v[g]     = {8'h00, bus.rx_data};
        spi_slave_cfg #(
            .DATA_WIDTH (8),
            .CPOL       (g >= 2),
            .CPHA       (g % 2 == 1),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    spi_slave_cfg_if #(.DATA_WIDTH(16)) bus16 ();
    assign bus16.SCLK     = sclk_base;
    assign bus16.MOSI     = mosi;
    assign bus16.SS_n     = ss_n_v[4];
    assign bus16.tx_data  = tx_data;
    assign bus16.tx_valid = txv_v[4];
    assign miso_v[4]      = bus16.MISO;
    assign rxv_v[4]       = bus16.rx_valid;
    assign txr_v[4]       = bus16.tx_ready;
    assign busy_v[4]      = bus16.busy;
    assign rxd_v[4]       = bus16.rx_data;
    spi_slave_cfg #(
        .DATA_WIDTH (16),
        .CPOL       (1'b0),
        .CPHA       (1'b0),
        .SYNC_STAGES(2)
    ) u_dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16)
    );

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic und0;
    assign und0 = g_mode[0].bus.tx_underrun;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit cpha_of(input int d);
        return (d < 4) && (d % 2 == 1);
    endfunction

    task automatic load_tx(input int d, input logic [15:0] w);
        int t = 0;
        while (!txr_v[d] && t < 50) begin
            wait_clk(1);
            t++;
        end
        check_eq("tx_ready_wait", 32'(txr_v[d]), 32'd1);
        tx_data  = w;
        txv_v[d] = 1'b1;
        wait_clk(1);
        txv_v[d] = 1'b0;
        check_eq("tx_ready_full", 32'(txr_v[d]), 32'd0);
    endtask

    task automatic ss_low(input int d);
        sel       = d;
        ss_n_v[d] = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_high(input int d);
        wait_clk(H);
        ss_n_v[d] = 1'b1;
        wait_clk(H);
    endtask

    // Master: drives MOSI MSB first and collects MISO on the master's sample edge.
    task automatic xfer(input int nbits, input logic [15:0] mo, input int width,
                        output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_of(sel)) begin
                mosi = mo[width-1-i];
                wait_clk(H);
                mi = {mi[14:0], miso_v[sel]};
                sclk_base = 1'b1;
                wait_clk(H);
                sclk_base = 1'b0;
            end else begin
                sclk_base = 1'b1;
                mosi = mo[width-1-i];
                wait_clk(H);
                mi = {mi[14:0], miso_v[sel]};
                sclk_base = 1'b0;
                wait_clk(H);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < NDut; d++) begin
                if (rxv_v[d]) begin
                    check_eq("rx_strobe_width", 32'(rxv_prev[d]), 32'd0);
                    check_eq("rx_src", 32'(d), 32'(sel));
                    check_eq("rx_pending", 32'(rx_exp.size() != 0), 32'd1);
                    if (rx_exp.size() != 0) begin
                        check_eq("rx_data", 32'(rxd_v[d]), 32'(rx_exp.pop_front()));
                    end
                end
            end
        end
        rxv_prev <= rxv_v;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mi;
        logic [15:0] rx_words [3];
        logic [15:0] tx_words [3];
        int          und_cnt;
        rx_words = '{16'h0011, 16'h0022, 16'h0033};
        tx_words = '{16'h00C1, 16'h00C2, 16'h00C3};

        wait_clk(3);
        for (int d = 0; d < NDut; d++) begin
            check_eq("rst_miso", 32'(miso_v[d]), 32'd0);
            check_eq("rst_rx_data", 32'(rxd_v[d]), 32'd0);
            check_eq("rst_rx_valid", 32'(rxv_v[d]), 32'd0);
            check_eq("rst_tx_ready", 32'(txr_v[d]), 32'd1);
            check_eq("rst_busy", 32'(busy_v[d]), 32'd0);
        end
        rst = 1'b0;
        wait_clk(4);

        // Single word in each of the four modes.
        for (int d = 0; d < 4; d++) begin
            load_tx(d, 16'h003C);
            ss_low(d);
            check_eq("busy", 32'(busy_v[d]), 32'd1);
            check_eq("tx_ready_after_load", 32'(txr_v[d]), 32'd1);
            rx_exp.push_back(16'h00A5);
            xfer(8, 16'h00A5, 8, mi);
            ss_high(d);
            check_eq("mode_miso_word", 32'(mi), 32'h3C);
            check_eq("mode_rx_done", 32'(rx_exp.size()), 32'd0);
            check_eq("idle_miso", 32'(miso_v[d]), 32'd0);
            check_eq("idle_busy", 32'(busy_v[d]), 32'd0);
        end

        // Three back-to-back words, holding register refilled after the first reload.
        for (int d = 0; d < 2; d++) begin
            load_tx(d, tx_words[0]);
            ss_low(d);
            load_tx(d, tx_words[1]);
            for (int w = 0; w < 3; w++) begin
                rx_exp.push_back(rx_words[w]);
                xfer(8, rx_words[w], 8, mi);
                check_eq("multi_miso_word", 32'(mi), 32'(tx_words[w]));
                if (w == 0) begin
                    load_tx(d, tx_words[2]);
                end
            end
            ss_high(d);
            check_eq("multi_rx_done", 32'(rx_exp.size()), 32'd0);
        end

        // Abort after 5 bits, then a full word must realign from bit 0.
        ss_low(0);
        xfer(5, 16'h00FF, 8, mi);
        ss_high(0);
        check_eq("abort_rx_data", 32'(rxd_v[0]), 32'h33);
        check_eq("abort_miso", 32'(miso_v[0]), 32'd0);
        load_tx(0, 16'h0096);
        ss_low(0);
        rx_exp.push_back(16'h005A);
        xfer(8, 16'h005A, 8, mi);
        ss_high(0);
        check_eq("post_abort_miso_word", 32'(mi), 32'h96);
        check_eq("post_abort_rx_done", 32'(rx_exp.size()), 32'd0);

        // Empty holding register: zeros go out (and an underrun pulse when enabled).
        sel       = 0;
        ss_n_v[0] = 1'b0;
        und_cnt   = 0;
        for (int i = 0; i < H; i++) begin
            wait_clk(1);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
            und_cnt += int'(und0);
`endif
        end
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check_eq("underrun_pulses", 32'(und_cnt), 32'd1);
`endif
        rx_exp.push_back(16'h0077);
        xfer(8, 16'h0077, 8, mi);
        ss_high(0);
        check_eq("empty_miso_word", 32'(mi), 32'd0);
        check_eq("empty_rx_done", 32'(rx_exp.size()), 32'd0);

        // 16-bit instance, then rst in the middle of a word.
        load_tx(4, 16'h1234);
        ss_low(4);
        rx_exp.push_back(16'hBEEF);
        xfer(16, 16'hBEEF, 16, mi);
        ss_high(4);
        check_eq("w16_miso_word", 32'(mi), 32'h1234);
        check_eq("w16_rx_done", 32'(rx_exp.size()), 32'd0);
        check_eq("w16_rx_held", 32'(rxd_v[4]), 32'hBEEF);

        load_tx(4, 16'hAAAA);
        ss_low(4);
        load_tx(4, 16'h5555);
        xfer(7, 16'hFFFF, 16, mi);
        rst = 1'b1;
        wait_clk(1);
        check_eq("midrst_miso", 32'(miso_v[4]), 32'd0);
        check_eq("midrst_rx_data", 32'(rxd_v[4]), 32'd0);
        check_eq("midrst_rx_valid", 32'(rxv_v[4]), 32'd0);
        check_eq("midrst_tx_ready", 32'(txr_v[4]), 32'd1);
        check_eq("midrst_busy", 32'(busy_v[4]), 32'd0);
        rst = 1'b0;

        // Select still low after rst: a full word of clocks must not produce anything.
        xfer(16, 16'hFFFF, 16, mi);
        ss_high(4);
        check_eq("no_resume_miso", 32'(mi), 32'd0);
        check_eq("no_resume_rx_data", 32'(rxd_v[4]), 32'd0);

        load_tx(4, 16'h0F0F);
        ss_low(4);
        rx_exp.push_back(16'hC3C3);
        xfer(16, 16'hC3C3, 16, mi);
        ss_high(4);
        check_eq("resume_miso_word", 32'(mi), 32'h0F0F);
        check_eq("resume_rx_done", 32'(rx_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
